fifo_read_ctrl: RTL and testbench

//  Read-side controller of the FIFO; sits directly upstream of the empty comparator.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_out_skid.sv | 72 +++++++
 rtl/fifo_read_ctrl.sv | 58 +++++
 tb/tb_fifo_read_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer/data width defaults and pointer types.
// The read controller and the empty comparator must agree on these.
package fifo_pkg;

  localparam int FIFO_SIZE   = 4;
  localparam int FIFO_DATA_W = 8;

  typedef logic [FIFO_SIZE-1:0] ptr_t;
  typedef logic [FIFO_SIZE-2:0] addr_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry FIFO-ordered output buffer.
// Accepts one word per cycle and presents the oldest word on a valid/ready port.
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              pop,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vld_q;

  // A ready with nothing valid is ignored.
  assign pop        = vld_q & rd_ready;
  assign dout       = head_q;
  assign dout_valid = vld_q;
  assign count      = cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({wr_en, pop})
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) head_d = wr_data;
        else               tail_d = wr_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        // Replace-in-place keeps the stream bubble-free at count 1.
        if (cnt_q == 2'd1) begin
          head_d = wr_data;
        end else begin
          head_d = tail_q;
          tail_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      assert (!(wr_en && cnt_q == 2'd2));
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= (cnt_d != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: owns the read pointer, issues memory reads and
// feeds returned words into a 2-entry output buffer at up to one word per cycle.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE   = FIFO_SIZE,
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_flag,
  output logic [SIZE-1:0]   r_pointer,
  output logic              rd_en,
  output logic [SIZE-2:0]   rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              rd_ready
);

  logic [SIZE-1:0] ptr_q;
  logic            inflight_q;
  logic            pop;
  logic [1:0]      count;
  logic [2:0]      credit;

  // Buffer slots already spoken for; the in-flight read always lands next cycle.
  assign credit = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en  = !rst && !e_flag && (credit < 3'd2);

  assign r_pointer = ptr_q;
  assign rd_addr   = ptr_q[SIZE-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (rd_en) ptr_q <= ptr_q + {{(SIZE-1){1'b0}}, 1'b1};
      inflight_q <= rd_en;
    end
  end

  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (inflight_q),
    .wr_data    (mem_rdata),
    .rd_ready   (rd_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .pop        (pop),
    .count      (count)
  );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural 1-cycle memory and
// a scoreboard of words owed to the consumer.
module tb_fifo_read_ctrl;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_flag;
  ptr_t        r_pointer;
  logic        rd_en;
  addr_t       rd_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        rd_ready;

  fifo_read_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .e_flag     (e_flag),
    .r_pointer  (r_pointer),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rd_ready   (rd_ready)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_pop  = 0;
  logic [7:0] mem [8];
  logic [7:0] nxt = 8'h10;
  logic [7:0] q [$];

  // Pre-edge snapshot of the cycle just stepped.
  logic       s_rd_en, s_valid;
  ptr_t       s_ptr;
  addr_t      s_addr;
  logic [7:0] s_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; inputs must be set just after a falling edge.
  task automatic step();
    logic       rd_s;
    logic [7:0] data;
    #1;
    s_rd_en = rd_en; s_valid = dout_valid; s_ptr = r_pointer;
    s_addr  = rd_addr; s_dout = dout;
    rd_s = rd_en && !rst;
    if (rst) begin
      q.delete();
    end else if (dout_valid && rd_ready) begin
      n_pop++;
      if (q.size() == 0) chk("pop_underflow", {24'h0, dout}, 32'hFFFF_FFFF);
      else chk("pop_data", {24'h0, dout}, {24'h0, q.pop_front()});
    end
    data = mem[rd_addr];
    if (rd_s) begin
      q.push_back(data);
      mem[rd_addr] = nxt;
      nxt = nxt + 8'd1;
    end
    @(posedge clk);
    #1;
    mem_rdata = rd_s ? data : 8'hEE;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h80 + 8'(i);
    rst = 1'b1; e_flag = 1'b0; rd_ready = 1'b0; mem_rdata = 8'hEE;
    @(negedge clk);

    // Reset: two cycles with e_flag low, then one quiet cycle.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_rd_en", {31'h0, s_rd_en}, 32'h0);
      chk("rst_ptr", {28'h0, s_ptr}, 32'h0);
      chk("rst_valid", {31'h0, s_valid}, 32'h0);
    end
    rst = 1'b0; e_flag = 1'b1;
    step();
    chk("post_rst_rd_en", {31'h0, s_rd_en}, 32'h0);
    chk("post_rst_ptr", {28'h0, s_ptr}, 32'h0);
    chk("post_rst_valid", {31'h0, s_valid}, 32'h0);

    // Single word.
    mem[0] = 8'hA5;
    e_flag = 1'b0; rd_ready = 1'b1;
    step();
    chk("sw_rd_en_t", {31'h0, s_rd_en}, 32'h1);
    chk("sw_addr_t", {29'h0, s_addr}, 32'h0);
    e_flag = 1'b1;
    step();
    chk("sw_ptr_t1", {28'h0, s_ptr}, 32'h1);
    chk("sw_valid_t1", {31'h0, s_valid}, 32'h0);
    step();
    chk("sw_valid_t2", {31'h0, s_valid}, 32'h1);
    chk("sw_dout_t2", {24'h0, s_dout}, 32'hA5);
    step();
    chk("sw_valid_t3", {31'h0, s_valid}, 32'h0);

    // Streaming 16 words from pointer 0; must wrap and run gap-free.
    rst = 1'b1; step(); rst = 1'b0;
    e_flag = 1'b0; rd_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("st_rd_en", {31'h0, s_rd_en}, 32'h1);
      chk("st_ptr", {28'h0, s_ptr}, 32'(i % 16));
      chk("st_addr", {29'h0, s_addr}, 32'(i % 8));
      if (i >= 2) chk("st_no_gap", {31'h0, s_valid}, 32'h1);
    end
    e_flag = 1'b1;
    step();
    chk("st_wrap_ptr", {28'h0, s_ptr}, 32'h0);
    chk("st_stop_rd_en", {31'h0, s_rd_en}, 32'h0);
    step(); step();
    chk("st_count", 32'(n_pop - p0), 32'd16);
    chk("st_drained", {31'h0, dout_valid}, 32'h0);

    // Backpressure: only two words may be taken on, then the pointer freezes.
    e_flag = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_rd_en", {31'h0, s_rd_en}, (i < 2) ? 32'h1 : 32'h0);
      if (i >= 2) chk("bp_ptr", {28'h0, s_ptr}, 32'h2);
      if (i >= 2) chk("bp_valid", {31'h0, s_valid}, 32'h1);
    end
    chk("bp_buffered", 32'(q.size()), 32'd2);
    rd_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("bp_resume_valid", {31'h0, s_valid}, 32'h1);
      chk("bp_resume_rd_en", {31'h0, s_rd_en}, 32'h1);
    end
    chk("bp_resume_pops", 32'(n_pop - p0), 32'd8);
    e_flag = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Empty mid-stream: three issues, then e_flag rises and blocks the fourth.
    e_flag = 1'b0; rd_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("em_rd_en", {31'h0, s_rd_en}, 32'h1);
    end
    e_flag = 1'b1;
    step();
    chk("em_blocked", {31'h0, s_rd_en}, 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("em_delivered", 32'(n_pop - p0), 32'd3);

    // Reset mid-operation with a full buffer and then with a read in flight.
    e_flag = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; rd_ready = 1'b1;
    step();
    rst = 1'b0; e_flag = 1'b1;
    step();
    chk("mr_full_valid", {31'h0, s_valid}, 32'h0);
    chk("mr_full_ptr", {28'h0, s_ptr}, 32'h0);
    e_flag = 1'b0;
    step(); step();
    chk("mr_inflight_setup", {31'h0, s_rd_en}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; e_flag = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_if_valid", {31'h0, s_valid}, 32'h0);
      chk("mr_if_ptr", {28'h0, s_ptr}, 32'h0);
    end
    chk("mr_no_output", 32'(n_pop - p0), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
